// File: rtl/m81_scan_ctrl_pkg.sv
// Shared definitions for the m81 scan controller.
// Contents: channel count and select width, settle-count range and counter
// width, controller state encoding, and a helper that sizes the settle reload
// value to the counter width.
package m81_scan_ctrl_pkg;

  localparam int NUM_CH     = 8;
  localparam int SEL_W      = 3;
  localparam int SETTLE_MAX = 15;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Settle reload value at counter width. Values above SETTLE_MAX do not fit
  // and are not legal.
  function automatic logic [CNT_W-1:0] settle_load(input int settle);
    return CNT_W'(settle);
  endfunction

endpackage

// File: rtl/m81_scan_ctrl_if.sv
// Signal bundle between a host, the m81 multiplexer and the scan controller.
//   start, en_mask : host -> controller   (scan request, channel enables)
//   mux_out        : m81  -> controller   (selected data input)
//   S0, S1, S2     : controller -> m81    (select, S0 = LSB)
//   sample         : controller -> host   (captured channel values)
//   busy, done     : controller -> host   (scan in progress, completion pulse)
// Modport master: host/mux side. Modport slave: controller side.
interface m81_scan_ctrl_if;
  import m81_scan_ctrl_pkg::*;

  logic              start;
  logic [NUM_CH-1:0] en_mask;
  logic              mux_out;
  logic              S0;
  logic              S1;
  logic              S2;
  logic [NUM_CH-1:0] sample;
  logic              busy;
  logic              done;

  modport master (
    output start, en_mask, mux_out,
    input  S0, S1, S2, sample, busy, done
  );

  modport slave (
    input  start, en_mask, mux_out,
    output S0, S1, S2, sample, busy, done
  );

endinterface

// File: rtl/m81_scan_ctrl_next_ch.sv
// m81_next_ch: next-enabled-channel search.
// Ports:
//   mask : channel enables
//   cur  : current channel index
//   incl : 1 = cur itself is a candidate (first-channel search from 0),
//          0 = only channels strictly above cur are candidates
//   nxt  : lowest enabled candidate channel (0 when none)
//   none : no enabled candidate channel remains
module m81_next_ch
  import m81_scan_ctrl_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  input  logic              incl,
  output logic [SEL_W-1:0]  nxt,
  output logic              none
);

  // Scanning downward lets the lowest qualifying channel win.
  always_comb begin
    nxt  = '0;
    none = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(cur)) || (incl && (i == int'(cur))))) begin
        nxt  = SEL_W'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/m81_scan_ctrl.sv
// m81_scan_ctrl: steps an 8:1 multiplexer (m81) through the enabled channels
// in ascending order and captures each selected value into sample.
// Parameter:
//   SETTLE : idle cycles between a select change and its capture (0..15)
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of m81_scan_ctrl_if (start/en_mask/mux_out in;
//              S0..S2/sample/busy/done out, all registered)
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | waiting for start; select and sample hold
// ST_SETTLE  | select driven, counting down settle cycles
// ST_CAPTURE | mux_out captured into sample[select] on this edge
// ST_DONE    | done pulse, busy low; back to ST_IDLE next edge
module m81_scan_ctrl
  import m81_scan_ctrl_pkg::*;
#(
  parameter int SETTLE = 1
)(
  input logic            clk,
  input logic            rst,
  m81_scan_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] SETTLE_CNT = settle_load(SETTLE);
  // With no settle time the capture edge follows the select edge directly,
  // so ST_SETTLE is bypassed. Otherwise ST_SETTLE lasts SETTLE cycles and
  // ST_CAPTURE one more, giving SETTLE+1 cycles per channel.
  localparam state_t AFTER_SEL = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0] mask_q;
  logic [SEL_W-1:0]  sel_q;
  logic [NUM_CH-1:0] sample_q;
  logic              busy_q;
  logic              done_q;

  logic [NUM_CH-1:0] srch_mask;
  logic [SEL_W-1:0]  srch_cur;
  logic              srch_incl;
  logic [SEL_W-1:0]  nxt_ch;
  logic              none_left;

  // In IDLE the search looks at the live enables from channel 0 upward;
  // during a scan it looks above the current channel in the latched mask.
  assign srch_mask = (state == ST_IDLE) ? bus.en_mask : mask_q;
  assign srch_cur  = (state == ST_IDLE) ? '0 : sel_q;
  assign srch_incl = (state == ST_IDLE);

  m81_next_ch u_next_ch (
    .mask (srch_mask),
    .cur  (srch_cur),
    .incl (srch_incl),
    .nxt  (nxt_ch),
    .none (none_left)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      mask_q   <= '0;
      sel_q    <= '0;
      sample_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            mask_q   <= bus.en_mask;
            sample_q <= '0;
            if (none_left) begin
              state  <= ST_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              sel_q  <= nxt_ch;
              cnt    <= SETTLE_CNT;
              busy_q <= 1'b1;
              state  <= AFTER_SEL;
            end
          end
        end
        ST_SETTLE: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          sample_q[sel_q] <= bus.mux_out;
          if (none_left) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            sel_q <= nxt_ch;
            cnt   <= SETTLE_CNT;
            state <= AFTER_SEL;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.S0     = sel_q[0];
  assign bus.S1     = sel_q[1];
  assign bus.S2     = sel_q[2];
  assign bus.sample = sample_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_m81_scan_ctrl.sv
// Testbench for m81_scan_ctrl. Two controllers (SETTLE=1 and SETTLE=0) share
// start/en_mask/rst and each drives its own m81 mux fed from the shared
// D7..D0 source. Stimulus pushes expected {sample, done cycle} per DUT into
// a queue; per-DUT monitors pop and compare on every done pulse.
module tb_m81_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] en_mask = 8'h00;
  logic [7:0] d_src = 8'h00;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] s;
    int         c;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];

  m81_scan_ctrl_if b1 ();
  m81_scan_ctrl_if b0 ();

  assign b1.start   = start;
  assign b1.en_mask = en_mask;
  assign b1.mux_out = d_src[{b1.S2, b1.S1, b1.S0}];
  assign b0.start   = start;
  assign b0.en_mask = en_mask;
  assign b0.mux_out = d_src[{b0.S2, b0.S1, b0.S0}];

  m81_scan_ctrl #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  m81_scan_ctrl #(.SETTLE(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (b1.done === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL s1_unexpected_done: cycle %0d got done=1 expected done=0", cyc);
      end else begin
        e = q1.pop_front();
        chk("s1_sample", b1.sample, e.s);
        chk("s1_done_cycle", cyc, e.c);
        chk("s1_busy_in_done", b1.busy, 0);
      end
    end
  end

  always @(negedge clk) begin : mon0
    exp_t e;
    if (b0.done === 1'b1) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL s0_unexpected_done: cycle %0d got done=1 expected done=0", cyc);
      end else begin
        e = q0.pop_front();
        chk("s0_sample", b0.sample, e.s);
        chk("s0_done_cycle", cyc, e.c);
        chk("s0_busy_in_done", b0.busy, 0);
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_s1_sel"}, {b1.S2, b1.S1, b1.S0}, 0);
    chk({tag, "_s1_sample"}, b1.sample, 0);
    chk({tag, "_s1_busy"}, b1.busy, 0);
    chk({tag, "_s1_done"}, b1.done, 0);
    chk({tag, "_s0_sel"}, {b0.S2, b0.S1, b0.S0}, 0);
    chk({tag, "_s0_sample"}, b0.sample, 0);
    chk({tag, "_s0_busy"}, b0.busy, 0);
    chk({tag, "_s0_done"}, b0.done, 0);
  endtask

  // Pulse start for one edge (edge S) and queue expectations: done observed in
  // the cycle after edge S+lat. Returns at the negedge following edge S.
  task automatic scan(input logic [7:0] mask, input logic [7:0] d, input logic [7:0] exp_s,
                      input int lat1, input int lat0, output int s);
    @(negedge clk);
    d_src   = d;
    en_mask = mask;
    start   = 1'b1;
    s       = cyc + 1;
    q1.push_back('{exp_s, s + lat1});
    q0.push_back('{exp_s, s + lat0});
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int s;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // All channels, SETTLE=1 captures on edges 2..16, SETTLE=0 on 1..8.
    scan(8'hFF, 8'hA5, 8'hA5, 16, 8, s);
    repeat (18) @(negedge clk);
    chk("s1_hold", b1.sample, 8'hA5);
    chk("s0_hold", b0.sample, 8'hA5);

    // Channels 0 and 7 only: select 0 then 7.
    scan(8'h81, 8'hFF, 8'h81, 4, 2, s);
    chk("s1_sel_first", {b1.S2, b1.S1, b1.S0}, 0);
    chk("s1_sample_cleared", b1.sample, 0);
    chk("s1_busy", b1.busy, 1);
    chk("s0_sel_first", {b0.S2, b0.S1, b0.S0}, 0);
    @(negedge clk);
    chk("s0_sel_second", {b0.S2, b0.S1, b0.S0}, 7);
    chk("s1_sel_hold", {b1.S2, b1.S1, b1.S0}, 0);
    @(negedge clk);
    chk("s1_sel_second", {b1.S2, b1.S1, b1.S0}, 7);
    repeat (6) @(negedge clk);
    chk("s1_sel_idle_hold", {b1.S2, b1.S1, b1.S0}, 7);

    // Disabled channels read 0 even when their data input is 1.
    scan(8'h3C, 8'hFF, 8'h3C, 8, 4, s);
    repeat (10) @(negedge clk);
    scan(8'h80, 8'h80, 8'h80, 2, 1, s);
    repeat (4) @(negedge clk);

    // Empty mask: straight to DONE on the start edge, busy never high.
    scan(8'h00, 8'hFF, 8'h00, 0, 0, s);
    chk("s1_busy_zero_mask", b1.busy, 0);
    chk("s0_busy_zero_mask", b0.busy, 0);
    @(negedge clk);
    chk("s1_done_one_cycle", b1.done, 0);
    repeat (3) @(negedge clk);

    // Mid-scan en_mask/start changes are ignored.
    scan(8'hFF, 8'h3C, 8'h3C, 16, 8, s);
    repeat (3) @(negedge clk);
    en_mask = 8'h00;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);

    // start held high over edges S..S+4: back-to-back scans.
    @(negedge clk);
    en_mask = 8'h01;
    d_src   = 8'h01;
    start   = 1'b1;
    s       = cyc + 1;
    q1.push_back('{8'h01, s + 2});
    q1.push_back('{8'h01, s + 6});
    q0.push_back('{8'h01, s + 1});
    q0.push_back('{8'h01, s + 4});
    repeat (5) @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);

    // Reset at edge S+5 of a full scan aborts with no done pulse.
    @(negedge clk);
    en_mask = 8'hFF;
    d_src   = 8'hA5;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("abort");
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Full scan after the abort.
    scan(8'hFF, 8'hA5, 8'hA5, 16, 8, s);
    repeat (18) @(negedge clk);

    chk("s1_queue_drained", q1.size(), 0);
    chk("s0_queue_drained", q0.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m81_scan_ctrl.md
M81_SCAN_CTRL -- requirements
Module: m81_scan_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 1, legal 0..15: idle cycles between select change and sample capture.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request one scan; honoured only in IDLE.
REQ-005 SHALL have port en_mask  input  8  channel enable; bit n enables m81 input Dn.
REQ-006 SHALL have port mux_out  input  1  the m81 out signal.
REQ-007 SHALL have ports S0, S1, S2  output  1 each  m81 select, S0 = LSB, registered.
REQ-008 SHALL have port sample  output  8  captured channel values; bit n = value of Dn.
REQ-009 SHALL have port busy  output  1  high while a scan is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse on scan completion.

Function
REQ-011 SHALL implement states IDLE, SETTLE, CAPTURE, DONE.
REQ-012 In IDLE, on an edge with start=1, SHALL latch en_mask into an internal mask, clear sample to 0, and assert busy.
- If latched mask != 0: drive {S2,S1,S0} = lowest enabled channel and go to SETTLE with the settle counter = SETTLE.
- If latched mask == 0: go directly to DONE.
REQ-013 SETTLE SHALL decrement the counter once per cycle and go to CAPTURE when it reaches 0; with SETTLE=0 it SHALL pass through in one cycle.
REQ-014 CAPTURE SHALL write mux_out into sample[current channel] on that edge, then:
- if a higher enabled channel remains, drive select to the next enabled channel (ascending) and return to SETTLE;
- otherwise go to DONE.
REQ-015 Timing: select for a channel SHALL change on edge E and its capture SHALL occur on edge E+SETTLE+1; each enabled channel costs exactly SETTLE+1 cycles.
REQ-016 DONE SHALL assert done for exactly one cycle with busy=0, then return to IDLE; sample SHALL hold until the next accepted start or reset.
REQ-017 Disabled channels SHALL be skipped with no cycles spent, and their sample bits SHALL read 0.
REQ-018 start and en_mask changes while busy=1 or in DONE SHALL be ignored; the latched mask alone governs the scan.
REQ-019 start held high continuously SHALL launch a new scan on the first edge after DONE, i.e. back-to-back scans.
REQ-020 Select outputs SHALL hold their last value in IDLE and DONE.

Reset
REQ-021 While rst=1 at an edge, state SHALL become IDLE and outputs SHALL be S0=S1=S2=0, sample=0, busy=0, done=0.
REQ-022 rst SHALL take priority over start and SHALL abort a scan mid-operation with no done pulse.

Structure
REQ-023 A shared package SHALL hold the state encoding, NUM_CH=8, SEL_W=3 and the SETTLE upper bound.
REQ-024 The next-enabled-channel search (mask plus current index to next index and a "none left" flag) SHALL be one combinational sub-module, m81_next_ch.
REQ-025 The bench SHALL instantiate m81_scan_ctrl driving a real m81, with D0..D7 as the data source.

Verification
REQ-026 SETTLE=1, D7..D0 held at 8'hA5, en_mask=8'hFF, start pulsed at edge 0 -> captures on edges 2,4,...,16; done high in the cycle after edge 16; sample=8'hA5.
REQ-027 SETTLE=1, D=8'hFF, en_mask=8'h81 -> select 0 then 7, captures on edges 2 and 4, sample=8'h81, done in the cycle after edge 4.
REQ-028 en_mask=8'h00, start at edge 0 -> DONE entered on edge 0, done pulse in the following cycle, sample=8'h00, busy never observed high for more than that edge.
REQ-029 SETTLE=0, en_mask=8'hFF, D=8'h3C -> one capture per cycle on edges 1..8, sample=8'h3C; mid-scan en_mask change has no effect.
REQ-030 rst asserted at edge 5 of a SETTLE=1, mask 8'hFF scan -> IDLE on edge 5, all outputs 0, no done pulse; a subsequent start yields a full correct scan.
